spindle_spi_master: RTL and testbench

Board-1 SPI master that ships each simulation step's 32-bit float muscle length to the board-2 spindle slave and, in the same full-duplex frame, collects the returned 32-bit Ia firing rate. It sits directly upstream of the spindle board: its `MOSI`/`SCK`/`SSEL` pins drive the spindle slave's inputs over the JP1→JP2 cable, and the slave's `MISO` comes back to it. One frame is launched per `sim_clk` rising edge.

---
 rtl/spindle_spi_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_spindle_spi_master.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spindle_spi_master.sv
// -----------------------------------------------------------------------------
// spindle_spi_master
//
// Board-1 SPI master (mode 0, MSB first). Each request ships one DATA_W-bit
// word (muscle length) to the spindle slave on MOSI and, in the same
// full-duplex frame, collects the slave's DATA_W-bit reply (Ia firing rate)
// from MISO.
//
// Frame shape, with N = max(clkdiv,1) latched at frame start:
//   SETUP  N    : SSEL low, SCK low, MOSI already shows the MSB
//   SHIFT  64N  : 32 SCK high phases and 32 low phases. The last low phase
//                 follows the final falling edge.
//   HOLD   N    : SCK low, SSEL still low
//   GAP    N    : SSEL high before the next frame may start
// rx_valid pulses, and rx_data updates, on the edge that ends HOLD.
//
// Handshake: start is asynchronous to the frame engine. Each rising edge of
// start (after a 2-flop synchronizer) is one request. Requests are never
// back-pressured. One extra request can wait in a one-deep pending slot;
// further requests are dropped and counted in missed_cnt. rx_valid is a
// one-cycle strobe with no ready; rx_data holds its value until the next
// frame completes.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   clkdiv       SCK half-period in clk cycles (0 acts as 1), sampled at start
//   start        frame request; its rising edge requests one frame
//   data32       word to transmit, sampled at frame start
//   MISO         serial data from the slave
//   MOSI         serial data to the slave
//   SCK          serial clock, idle low
//   SSEL         slave select, active low
//   rx_data      last received word
//   rx_valid     one-cycle pulse when rx_data updates
//   busy         high from frame start to the end of GAP
//   missed_cnt   saturating count of dropped requests
//   o_dbg_state  current FSM state (debug)
// -----------------------------------------------------------------------------
module spindle_spi_master #(
   parameter int DATA_W   = 32,
   parameter int CLKDIV_W = 24
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CLKDIV_W-1:0] clkdiv,
   input  logic                start,
   input  logic [DATA_W-1:0]   data32,
   input  logic                MISO,
   output logic                MOSI,
   output logic                SCK,
   output logic                SSEL,
   output logic [DATA_W-1:0]   rx_data,
   output logic                rx_valid,
   output logic                busy,
   output logic [7:0]          missed_cnt,
   output logic [2:0]          o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam logic [5:0]          LP_LAST_BIT = 6'(DATA_W);
   localparam logic [5:0]          LP_LAST_M1  = 6'(DATA_W - 1);
   localparam logic [CLKDIV_W-1:0] LP_ONE      = CLKDIV_W'(1);

   state_t              r_state;
   logic                r_s1;
   logic                r_s2;
   logic                r_s3;
   logic                r_pending;
   logic [7:0]          r_missed;
   logic [CLKDIV_W-1:0] r_n;
   logic [CLKDIV_W-1:0] r_cnt;
   logic [5:0]          r_bits;
   logic [DATA_W-1:0]   r_tx;
   logic [DATA_W-1:0]   r_rx;
   logic [DATA_W-1:0]   r_rx_data;
   logic                r_sck;
   logic                r_ssel;
   logic                r_rx_valid;
   logic                r_busy;

   logic                w_req;
   logic                w_phase_end;
   logic                w_gap_done;
   logic                w_launch_pend;
   logic                w_launch_req;
   logic                w_launch;
   logic                w_req_busy;
   logic [CLKDIV_W-1:0] w_n;

   // start synchronizer plus one extra flop for rising-edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= start;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_req       = r_s2 & ~r_s3;
   assign w_n         = (clkdiv == '0) ? LP_ONE : clkdiv;
   assign w_phase_end = (r_cnt == LP_ONE);
   assign w_gap_done  = (r_state == ST_GAP) && w_phase_end;

   // A waiting request launches either straight out of GAP (no idle cycle,
   // so SSEL stays high for exactly one GAP) or from IDLE. The IDLE case
   // arises when the request landed on the same edge that GAP ended.
   assign w_launch_pend = r_pending && ((r_state == ST_IDLE) || w_gap_done);
   assign w_launch_req  = w_req && (r_state == ST_IDLE) && !r_pending;
   assign w_launch      = w_launch_pend || w_launch_req;
   // Any request that does not start a frame by itself counts as "while busy"
   assign w_req_busy    = w_req && !w_launch_req;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_pending  <= 1'b0;
         r_missed   <= 8'd0;
         r_n        <= LP_ONE;
         r_cnt      <= LP_ONE;
         r_bits     <= 6'd0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_rx_data  <= '0;
         r_sck      <= 1'b0;
         r_ssel     <= 1'b1;
         r_rx_valid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;

         // pending slot: a slot consumed this cycle can be refilled at once
         if (w_launch_pend) begin
            r_pending <= w_req_busy;
         end else if (w_req_busy) begin
            if (!r_pending) begin
               r_pending <= 1'b1;
            end else if (r_missed != 8'hFF) begin
               r_missed <= r_missed + 8'd1;
            end
         end

         if (w_launch) begin
            r_tx    <= data32;
            r_rx    <= '0;
            r_n     <= w_n;
            r_cnt   <= w_n;
            r_bits  <= 6'd0;
            r_sck   <= 1'b0;
            r_ssel  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_busy <= 1'b0;
               end

               ST_SETUP: begin
                  if (w_phase_end) begin
                     // first SCK rise: MISO is captured on this same edge
                     r_sck   <= 1'b1;
                     r_rx    <= {r_rx[DATA_W-2:0], MISO};
                     r_cnt   <= r_n;
                     r_state <= ST_SHIFT;
                  end else begin
                     r_cnt <= r_cnt - LP_ONE;
                  end
               end

               ST_SHIFT: begin
                  if (w_phase_end) begin
                     r_cnt <= r_n;
                     if (r_sck) begin
                        // falling edge: present the next bit, except after
                        // the last one, where MOSI just holds
                        r_sck  <= 1'b0;
                        r_bits <= r_bits + 6'd1;
                        if (r_bits != LP_LAST_M1) begin
                           r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                        end
                     end else if (r_bits == LP_LAST_BIT) begin
                        // low phase after the final falling edge is over
                        r_state <= ST_HOLD;
                     end else begin
                        r_sck <= 1'b1;
                        r_rx  <= {r_rx[DATA_W-2:0], MISO};
                     end
                  end else begin
                     r_cnt <= r_cnt - LP_ONE;
                  end
               end

               ST_HOLD: begin
                  if (w_phase_end) begin
                     r_ssel     <= 1'b1;
                     r_tx       <= '0;
                     r_rx_data  <= r_rx;
                     r_rx_valid <= 1'b1;
                     r_cnt      <= r_n;
                     r_state    <= ST_GAP;
                  end else begin
                     r_cnt <= r_cnt - LP_ONE;
                  end
               end

               ST_GAP: begin
                  if (w_phase_end) begin
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_cnt <= r_cnt - LP_ONE;
                  end
               end

               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign MOSI        = r_tx[DATA_W-1];
   assign SCK         = r_sck;
   assign SSEL        = r_ssel;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign busy        = r_busy;
   assign missed_cnt  = r_missed;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spindle_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spindle_spi_master
//
// Drives start/clkdiv/data32 and plays the spindle slave on MISO. A request-
// level model predicts, from frame-time arithmetic (67*N per frame, launch 2
// edges after start is first sampled high, one pending slot, saturating drop
// count), when every frame launches and what it carries. A monitor checks
// each observed frame against that prediction.
// -----------------------------------------------------------------------------
module tb_spindle_spi_master;

   // ---------------- clock / reset ----------------
   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        start   = 1'b0;
   logic [23:0] clkdiv  = 24'd0;
   logic [31:0] data32  = 32'd0;
   logic        MISO;
   logic        MOSI;
   logic        SCK;
   logic        SSEL;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        busy;
   logic [7:0]  missed_cnt;
   logic [2:0]  o_dbg_state;

   always #5 clk = ~clk;

   spindle_spi_master #(.DATA_W(32), .CLKDIV_W(24)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clkdiv      (clkdiv),
      .start       (start),
      .data32      (data32),
      .MISO        (MISO),
      .MOSI        (MOSI),
      .SCK         (SCK),
      .SSEL        (SSEL),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .missed_cnt  (missed_cnt),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] data;
      int          n;
      logic [31:0] sl;
      int          edge_at;
   } frame_t;

   frame_t      exp_q[$];
   int          req_q[$];
   int          cyc = 0;
   bit          m_active;
   bit          m_pending;
   bit          m_prev_start;
   int          m_end;
   int          m_missed;
   int          sl_mode = 0;        // 0 random reply, 1 fixed reply, 2 loopback
   logic [31:0] sl_fixed = 32'd0;

   task automatic m_launch(input int e);
      frame_t f;
      f.data    = data32;
      f.n       = (clkdiv == 24'd0) ? 1 : int'(clkdiv);
      f.sl      = (sl_mode == 1) ? sl_fixed : (sl_mode == 2) ? data32 : $urandom;
      f.edge_at = e;
      exp_q.push_back(f);
      m_active = 1'b1;
      m_end    = e + 67 * f.n;
   endtask

   always @(posedge clk) begin
      bit is_req;
      bit end_now;
      cyc++;
      if (!reset_n) begin
         m_active     = 1'b0;
         m_pending    = 1'b0;
         m_prev_start = 1'b0;
         m_missed     = 0;
         exp_q.delete();
         req_q.delete();
      end else begin
         is_req = 1'b0;
         if (req_q.size() > 0 && req_q[0] == cyc) begin
            void'(req_q.pop_front());
            is_req = 1'b1;
         end
         if (start && !m_prev_start) req_q.push_back(cyc + 2);
         m_prev_start = start;
         end_now = m_active && (cyc == m_end);
         if (end_now) begin
            m_active = 1'b0;
            if (m_pending) begin
               m_pending = 1'b0;
               m_launch(cyc);
            end
         end else if (!m_active && m_pending) begin
            m_pending = 1'b0;
            m_launch(cyc);
         end
         if (is_req) begin
            if (!m_active && !end_now) m_launch(cyc);
            else if (!m_pending)       m_pending = 1'b1;
            else if (m_missed < 255)   m_missed++;
         end
      end
   end

   // ---------------- slave model ----------------
   logic [31:0] sl_sh = 32'd0;
   assign MISO = sl_sh[31];

   always @(negedge SSEL) sl_sh = (exp_q.size() > 0) ? exp_q[0].sl : 32'd0;
   always @(negedge SCK) if (!SSEL) sl_sh = sl_sh << 1;

   // ---------------- monitor / scoreboard ----------------
   frame_t      cur;
   bit          in_frame  = 1'b0;
   int          fall_t;
   int          rises     = 0;
   int          rxv_cnt   = 0;
   logic [31:0] mosi_w;
   logic        prev_ssel = 1'b1;
   logic        prev_sck  = 1'b0;

   always @(negedge clk) begin
      if (!reset_n) begin
         in_frame  = 1'b0;
         prev_ssel = 1'b1;
         prev_sck  = 1'b0;
      end else begin
         if (prev_ssel && !SSEL) begin
            if (exp_q.size() == 0) begin
               chk("frame_expected", 32'(exp_q.size()), 32'd1);
            end else begin
               cur      = exp_q.pop_front();
               in_frame = 1'b1;
               fall_t   = cyc;
               rises    = 0;
               mosi_w   = 32'd0;
               chk("launch_edge", 32'(cyc), 32'(cur.edge_at));
               chk("busy_at_start", 32'(busy), 32'd1);
            end
         end
         if (!prev_sck && SCK && in_frame) begin
            chk("sck_rise_time", 32'(cyc - fall_t), 32'(cur.n * (2 * rises + 1)));
            mosi_w = {mosi_w[30:0], MOSI};
            rises++;
         end
         if (rx_valid) begin
            if (!in_frame) begin
               chk("spurious_rx_valid", 32'(rx_valid), 32'd0);
            end else begin
               chk("rxv_time", 32'(cyc - fall_t), 32'(66 * cur.n));
               chk("ssel_at_rxv", 32'(SSEL), 32'd1);
               chk("mosi_idle", 32'(MOSI), 32'd0);
               chk("rx_data", rx_data, cur.sl);
               chk("mosi_word", mosi_w, cur.data);
               chk("sck_rises", 32'(rises), 32'd32);
               in_frame = 1'b0;
            end
            rxv_cnt++;
         end
         prev_ssel = SSEL;
         prev_sck  = SCK;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse(input int width);
      @(negedge clk);
      start = 1'b1;
      repeat (width) @(negedge clk);
      start = 1'b0;
   endtask

   task automatic measure_busy(output int len);
      bit seen;
      seen = 1'b0;
      len  = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (busy) begin
            seen = 1'b1;
            len++;
         end else if (seen) begin
            break;
         end
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (!m_active && !m_pending && req_q.size() == 0 && exp_q.size() == 0 &&
             !busy && !in_frame) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_idle", 32'(ok), 32'd1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int len;
      int snap;
      bit ok;

      repeat (3) @(negedge clk);
      chk("rst_ssel", 32'(SSEL), 32'd1);
      chk("rst_sck", 32'(SCK), 32'd0);
      chk("rst_mosi", 32'(MOSI), 32'd0);
      chk("rst_rx_data", rx_data, 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_missed", 32'(missed_cnt), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // basic frame, N=13
      clkdiv   = 24'hD;
      data32   = 32'h3F80_0000;
      sl_mode  = 1;
      sl_fixed = 32'h4248_0000;
      pulse(1);
      measure_busy(len);
      chk("busy_len_n13", 32'(len), 32'd871);
      wait_idle();
      chk("rx_data_basic", rx_data, 32'h4248_0000);

      // minimum divider with loopback
      clkdiv  = 24'd0;
      data32  = 32'hA5A5_5A5A;
      sl_mode = 2;
      pulse(1);
      measure_busy(len);
      chk("busy_len_n1", 32'(len), 32'd67);
      wait_idle();
      chk("rx_data_loop", rx_data, 32'hA5A5_5A5A);

      // mid-frame input changes
      sl_mode = 0;
      clkdiv  = 24'd13;
      data32  = 32'h1234_5678;
      pulse(1);
      repeat (300) @(negedge clk);
      clkdiv = 24'd5;
      data32 = 32'hCAFE_F00D;
      wait_idle();
      pulse(1);
      measure_busy(len);
      chk("busy_len_n5", 32'(len), 32'd335);
      wait_idle();

      // overlapping requests: one pending, one dropped
      clkdiv = 24'd3;
      pulse(1);
      repeat (40) @(negedge clk);
      pulse(1);
      repeat (40) @(negedge clk);
      pulse(1);
      repeat (4) @(negedge clk);
      chk("missed_one", 32'(missed_cnt), 32'd1);
      wait_idle();
      chk("missed_model_a", 32'(missed_cnt), 32'(m_missed));

      // 300 more drops -> saturate
      clkdiv = 24'd20;
      repeat (302) pulse(1);
      repeat (4) @(negedge clk);
      chk("missed_sat", 32'(missed_cnt), 32'd255);
      chk("missed_model_b", 32'(missed_cnt), 32'(m_missed));
      wait_idle();

      // reset at bit 10
      clkdiv = 24'd13;
      pulse(1);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (in_frame && rises >= 10) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reach_bit10", 32'(ok), 32'd1);
      reset_n = 1'b0;
      snap = rxv_cnt;
      #1;
      chk("mid_rst_ssel", 32'(SSEL), 32'd1);
      chk("mid_rst_sck", 32'(SCK), 32'd0);
      chk("mid_rst_mosi", 32'(MOSI), 32'd0);
      chk("mid_rst_rx_data", rx_data, 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_missed", 32'(missed_cnt), 32'd0);
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (1000) @(negedge clk);
      chk("no_rxv_after_rst", 32'(rxv_cnt), 32'(snap));
      chk("idle_after_rst", 32'(SSEL), 32'd1);
      pulse(1);
      wait_idle();
      chk("rxv_clean_frame", 32'(rxv_cnt), 32'(snap + 1));

      // randomized traffic
      for (int t = 0; t < 25; t++) begin
         clkdiv = 24'($urandom_range(0, 6));
         data32 = $urandom;
         pulse($urandom_range(1, 3));
         repeat ($urandom_range(1, 300)) @(negedge clk);
      end
      wait_idle();
      chk("missed_model_rand", 32'(missed_cnt), 32'(m_missed));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
